db_fsm_delayed: RTL and testbench

Delayed-decision switch debouncer built around a state machine. It is the front-end stage that feeds the edge-detect/mod-10 counter logic and the seven-segment display path.
- Accepts a raw active-low mechanical switch and synchronizes it.
- Asserts a clean active-high level only after the input has been stable for STABLE_TICKS sample periods.
- Emits one-cycle rise and fall ticks, so downstream counters need no edge detector of their own.

---
 rtl/db_fsm_delayed.sv | 163 ++++++++++++++++
 tb/tb_db_fsm_delayed.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/db_fsm_delayed.sv
// db_fsm_delayed: delayed-decision switch debouncer.
//
// Takes a raw active-low mechanical switch, synchronizes it into clk and
// only changes the debounced level after the input has been stable for
// STABLE_TICKS consecutive sample ticks. One-cycle rise/fall pulses are
// emitted alongside the level so downstream counters need no edge detector.
//
// Ports:
//   clk        in   system clock, rising edge
//   rst        in   synchronous active-high reset
//   sw_low     in   raw switch, active low, asynchronous, may bounce
//   db         out  debounced level, 1 = pressed
//   tick_rise  out  one-cycle pulse on the first cycle db reads 1
//   tick_fall  out  one-cycle pulse on the first cycle db reads 0
//   bounce_cnt out  saturating count of aborted qualifications
//
// Optional feature macro: DB_BOUNCE_CNT_EN
//   defined   -> bounce_cnt counts WAIT1->ZERO and WAIT0->ONE transitions
//   undefined -> no counter is built, bounce_cnt is tied to 0
//
// State | meaning
// ZERO  | released, db = 0
// WAIT1 | input reads pressed, counting stable ticks, db = 0
// ONE   | pressed, db = 1
// WAIT0 | input reads released, counting stable ticks, db = 1

module db_fsm_delayed #(
  parameter int TICK_DIV     = 500000,
  parameter int STABLE_TICKS = 3,
  parameter int CNT_W        = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sw_low,
  output logic             db,
  output logic             tick_rise,
  output logic             tick_fall,
  output logic [CNT_W-1:0] bounce_cnt
);

  localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int WW = $clog2(STABLE_TICKS + 1);
  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
  localparam logic [WW-1:0] WAIT_LOAD = WW'(STABLE_TICKS);

  typedef enum logic [1:0] {
    ZERO  = 2'd0,
    WAIT1 = 2'd1,
    ONE   = 2'd2,
    WAIT0 = 2'd3
  } state_t;

  // Two-flop synchronizer; both flops idle at 1 (switch released).
  logic sync1_q, sync2_q;
  logic sw_s;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
    end else begin
      sync1_q <= sw_low;
      sync2_q <= sync1_q;
    end
  end

  assign sw_s = ~sync2_q;

  // Free-running sample tick divider.
  logic [TW-1:0] div_q, div_d;
  logic          tick;

  assign tick  = (div_q == TICK_LAST);
  assign div_d = tick ? '0 : div_q + TW'(1);

  always_ff @(posedge clk) begin
    if (rst) div_q <= '0;
    else     div_q <= div_d;
  end

  // FSM with registered outputs. A reversal of the input is tested before
  // the tick, so a reversal coinciding with the final tick aborts the wait.
  state_t        state_q;
  logic [WW-1:0] wait_q;
  logic          db_q, rise_q, fall_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ZERO;
      wait_q  <= '0;
      db_q    <= 1'b0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      rise_q <= 1'b0;
      fall_q <= 1'b0;
      case (state_q)
        ZERO: begin
          if (sw_s) begin
            state_q <= WAIT1;
            wait_q  <= WAIT_LOAD;
          end
        end
        WAIT1: begin
          if (!sw_s) begin
            state_q <= ZERO;
          end else if (tick) begin
            wait_q <= wait_q - WW'(1);
            if (wait_q == WW'(1)) begin
              state_q <= ONE;
              db_q    <= 1'b1;
              rise_q  <= 1'b1;
            end
          end
        end
        ONE: begin
          if (!sw_s) begin
            state_q <= WAIT0;
            wait_q  <= WAIT_LOAD;
          end
        end
        WAIT0: begin
          if (sw_s) begin
            state_q <= ONE;
          end else if (tick) begin
            wait_q <= wait_q - WW'(1);
            if (wait_q == WW'(1)) begin
              state_q <= ZERO;
              db_q    <= 1'b0;
              fall_q  <= 1'b1;
            end
          end
        end
        default: begin
          state_q <= ZERO;
          db_q    <= 1'b0;
        end
      endcase
    end
  end

  assign db        = db_q;
  assign tick_rise = rise_q;
  assign tick_fall = fall_q;

`ifdef DB_BOUNCE_CNT_EN
  logic             bounce_ev;
  logic [CNT_W-1:0] bcnt_q;

  assign bounce_ev = ((state_q == WAIT1) && !sw_s) ||
                     ((state_q == WAIT0) &&  sw_s);

  always_ff @(posedge clk) begin
    if (rst)                           bcnt_q <= '0;
    else if (bounce_ev && bcnt_q != '1) bcnt_q <= bcnt_q + CNT_W'(1);
  end

  assign bounce_cnt = bcnt_q;
`else
  assign bounce_cnt = '0;
`endif

endmodule

// File: tb/tb_db_fsm_delayed.sv
// Directed testbench for db_fsm_delayed with TICK_DIV=4, STABLE_TICKS=3.
// Inputs are driven and outputs sampled on the falling clock edge.

module tb_db_fsm_delayed;

  localparam int TICK_DIV     = 4;
  localparam int STABLE_TICKS = 3;
  localparam int CNT_W        = 8;

`ifdef DB_BOUNCE_CNT_EN
  localparam bit CNT_ON = 1'b1;
`else
  localparam bit CNT_ON = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             sw_low = 1'b1;
  logic             db, tick_rise, tick_fall;
  logic [CNT_W-1:0] bounce_cnt;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  db_fsm_delayed #(
    .TICK_DIV    (TICK_DIV),
    .STABLE_TICKS(STABLE_TICKS),
    .CNT_W       (CNT_W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .sw_low    (sw_low),
    .db        (db),
    .tick_rise (tick_rise),
    .tick_fall (tick_fall),
    .bounce_cnt(bounce_cnt)
  );

  function automatic logic [CNT_W-1:0] exp_cnt(input int n);
    return CNT_ON ? CNT_W'(n) : '0;
  endfunction

  task automatic test_reset();
    rst    = 1'b1;
    sw_low = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      checks++;
      if ({db, tick_rise, tick_fall, bounce_cnt} !== '0) begin
        failures++;
        $display("FAIL reset_outputs cycle=%0d got db=%b rise=%b fall=%b cnt=%0d want all 0",
                 i, db, tick_rise, tick_fall, bounce_cnt);
      end
    end
    rst = 1'b0;
    repeat (5) @(negedge clk);
    checks++;
    if ({db, tick_rise, tick_fall} !== 3'b000) begin
      failures++;
      $display("FAIL reset_idle got db=%b rise=%b fall=%b want 000", db, tick_rise, tick_fall);
    end
  endtask

  task automatic test_clean_press();
    int lat = 0, rises = 0, falls = 0;
    bit found = 0;
    sw_low = 1'b0;
    for (int n = 1; n <= 40; n++) begin
      @(negedge clk);
      if (tick_rise) rises++;
      if (tick_fall) falls++;
      if (!found && db) begin
        found = 1;
        lat   = n;
        checks++;
        if (tick_rise !== 1'b1) begin
          failures++;
          $display("FAIL press_rise_align got tick_rise=%b want 1 on first db cycle", tick_rise);
        end
      end
    end
    checks++;
    if (!found || lat < 12 || lat > 15) begin
      failures++;
      $display("FAIL press_latency got found=%0d lat=%0d want 12..15", found, lat);
    end
    checks++;
    if (rises != 1 || falls != 0) begin
      failures++;
      $display("FAIL press_pulses got rises=%0d falls=%0d want 1/0", rises, falls);
    end
  endtask

  task automatic test_release();
    int lat = 0, rises = 0, falls = 0;
    bit found = 0;
    sw_low = 1'b1;
    for (int n = 1; n <= 40; n++) begin
      @(negedge clk);
      if (tick_rise) rises++;
      if (tick_fall) falls++;
      if (!found && !db) begin
        found = 1;
        lat   = n;
        checks++;
        if (tick_fall !== 1'b1) begin
          failures++;
          $display("FAIL release_fall_align got tick_fall=%b want 1 on first db=0 cycle", tick_fall);
        end
      end
    end
    checks++;
    if (!found || lat < 12 || lat > 15) begin
      failures++;
      $display("FAIL release_latency got found=%0d lat=%0d want 12..15", found, lat);
    end
    checks++;
    if (rises != 0 || falls != 1) begin
      failures++;
      $display("FAIL release_pulses got rises=%0d falls=%0d want 0/1", rises, falls);
    end
  endtask

  task automatic test_bounce_press();
    int rises = 0, falls = 0;
    for (int i = 0; i < 12; i++) begin
      sw_low = ((i / 2) % 2 == 1);
      @(negedge clk);
      if (tick_rise) rises++;
      if (tick_fall) falls++;
    end
    checks++;
    if (db !== 1'b0 || rises != 0) begin
      failures++;
      $display("FAIL bounce_no_early got db=%b rises=%0d want 0/0", db, rises);
    end
    sw_low = 1'b0;
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      if (tick_rise) rises++;
      if (tick_fall) falls++;
    end
    checks++;
    if (db !== 1'b1 || rises != 1 || falls != 0) begin
      failures++;
      $display("FAIL bounce_press got db=%b rises=%0d falls=%0d want 1/1/0", db, rises, falls);
    end
    checks++;
    if (bounce_cnt !== exp_cnt(3)) begin
      failures++;
      $display("FAIL bounce_cnt_3 got %0d want %0d", bounce_cnt, exp_cnt(3));
    end
  endtask

  task automatic test_glitch();
    int drops = 0, pulses = 0;
    sw_low = 1'b1;
    for (int n = 0; n < 30; n++) begin
      @(negedge clk);
      if (n == 4) sw_low = 1'b0;
      if (!db) drops++;
      if (tick_rise || tick_fall) pulses++;
    end
    checks++;
    if (drops != 0 || pulses != 0) begin
      failures++;
      $display("FAIL glitch_hold got drops=%0d pulses=%0d want 0/0", drops, pulses);
    end
    checks++;
    if (bounce_cnt !== exp_cnt(4)) begin
      failures++;
      $display("FAIL glitch_cnt got %0d want %0d", bounce_cnt, exp_cnt(4));
    end
  endtask

  task automatic test_reset_mid();
    int lat, rises, falls;
    bit found;
    // Return to ZERO first.
    sw_low = 1'b1;
    found  = 0;
    for (int n = 0; n < 40 && !found; n++) begin
      @(negedge clk);
      if (!db) found = 1;
    end
    checks++;
    if (!found) begin
      failures++;
      $display("FAIL rstmid_release_timeout db=%b want 0 within 40 cycles", db);
    end
    repeat (4) @(negedge clk);

    // Reset while waiting in WAIT1.
    sw_low = 1'b0;
    repeat (6) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if ({db, tick_rise, tick_fall, bounce_cnt} !== '0) begin
      failures++;
      $display("FAIL rst_wait1 got db=%b rise=%b fall=%b cnt=%0d want all 0",
               db, tick_rise, tick_fall, bounce_cnt);
    end
    found = 0; lat = 0; rises = 0; falls = 0;
    for (int n = 1; n <= 25; n++) begin
      @(negedge clk);
      if (tick_rise) rises++;
      if (tick_fall) falls++;
      if (!found && db) begin found = 1; lat = n; end
    end
    checks++;
    if (!found || lat > 15 || rises != 1 || falls != 0) begin
      failures++;
      $display("FAIL rst_wait1_requal got found=%0d lat=%0d rises=%0d falls=%0d want lat<=15 1/0",
               found, lat, rises, falls);
    end

    // Reset while in ONE: db drops without a fall pulse.
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if (db !== 1'b0 || tick_fall !== 1'b0 || tick_rise !== 1'b0) begin
      failures++;
      $display("FAIL rst_one got db=%b rise=%b fall=%b want 000", db, tick_rise, tick_fall);
    end
    found = 0; lat = 0; rises = 0; falls = 0;
    for (int n = 1; n <= 25; n++) begin
      @(negedge clk);
      if (tick_rise) rises++;
      if (tick_fall) falls++;
      if (!found && db) begin found = 1; lat = n; end
    end
    checks++;
    if (!found || lat > 15 || rises != 1 || falls != 0) begin
      failures++;
      $display("FAIL rst_one_requal got found=%0d lat=%0d rises=%0d falls=%0d want lat<=15 1/0",
               found, lat, rises, falls);
    end
    checks++;
    if (bounce_cnt !== '0) begin
      failures++;
      $display("FAIL rst_cnt_clear got %0d want 0", bounce_cnt);
    end
  endtask

  // Rise and fall pulses must never overlap or repeat on consecutive cycles.
  int  pulse_viol = 0;
  logic prev_pulse = 1'b0;
  always @(negedge clk) begin
    if (tick_rise && tick_fall) pulse_viol++;
    if (prev_pulse && (tick_rise || tick_fall)) pulse_viol++;
    prev_pulse = tick_rise | tick_fall;
  end

  initial begin
    test_reset();
    test_clean_press();
    test_release();
    test_bounce_press();
    test_glitch();
    test_reset_mid();
    checks++;
    if (pulse_viol != 0) begin
      failures++;
      $display("FAIL pulse_rules got violations=%0d want 0", pulse_viol);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
